attitude_pd_mixer: RTL and testbench

Consumes the fused pitch/roll/yaw stream and its vld strobe from the inertial interface. Computes a PD correction per axis against desired attitude and mixes the corrections with thrust into four motor speed commands. The outputs drive the downstream ESC/PWM stage. Work is triggered only on vld and pipelined 3 cycles.

---
 rtl/attitude_pd_pkg.sv | 24 ++
 rtl/attitude_pd_mixer_pd_axis.sv | 62 ++++++
 rtl/attitude_pd_mixer.sv | 91 +++++++++
 tb/tb_attitude_pd_mixer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/attitude_pd_pkg.sv
// attitude_pd_pkg: shared types, speed constants and saturation helpers for attitude_pd_mixer
package attitude_pd_pkg;
   typedef logic [10:0]        spd_t;
   typedef logic signed [9:0]  err_t;
   typedef logic signed [6:0]  dsat_t;
   typedef logic signed [12:0] term_t;
   localparam spd_t  MIN_RUN_SPEED = 11'd512;
   localparam spd_t  CAL_SPEED     = 11'h290;
   localparam spd_t  SPD_MAX       = 11'd2047;
   localparam err_t  ERR_MAX       = err_t'(511);
   localparam err_t  ERR_MIN       = err_t'(-512);
   localparam dsat_t DSAT_MAX      = dsat_t'(63);
   localparam dsat_t DSAT_MIN      = dsat_t'(-64);
   // A value fits when every bit above the target sign bit equals the sign.
   function automatic err_t sat_err(input logic signed [16:0] x);
      return (x[16:9] == {8{x[16]}}) ? x[9:0] : (x[16] ? ERR_MIN : ERR_MAX);
   endfunction
   function automatic dsat_t sat_d(input logic signed [10:0] x);
      return (x[10:6] == {5{x[10]}}) ? x[6:0] : (x[10] ? DSAT_MIN : DSAT_MAX);
   endfunction
   function automatic spd_t clamp_spd(input term_t x);
      return x[12] ? '0 : (x[11] ? SPD_MAX : x[10:0]);
   endfunction
endpackage

// File: rtl/attitude_pd_mixer_pd_axis.sv
// pd_axis: per-axis error saturation and P/D terms (stages 1-2).
// The derivative queue and D term exist only when PD_DTERM_EN is defined.
module pd_axis
   import attitude_pd_pkg::*;
#(
   parameter int DEPTH   = 12,
   parameter int P_NUM   = 5,
   parameter int D_COEFF = 2
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               vld_i,
   input  logic               adv_i,
   input  logic signed [15:0] meas_i,
   input  logic signed [15:0] des_i,
   output term_t              p_o,
   output term_t              d_o
);
   localparam term_t PN = term_t'(P_NUM);
   localparam term_t DC = term_t'(D_COEFF);
   if (DEPTH < 2) begin : g_depth_chk
      $error("pd_axis: DEPTH must be at least 2");
   end
   logic signed [16:0] diff_full;
   err_t  err_d, err_q;
   dsat_t dsat;
   term_t p_d, d_d, p_q, d_q;
   assign diff_full = {meas_i[15], meas_i} - {des_i[15], des_i};
   assign err_d     = sat_err(diff_full);
`ifdef PD_DTERM_EN
   err_t q_q [DEPTH];
   logic signed [10:0] dd;
   assign dd   = {err_q[9], err_q} - {q_q[DEPTH-1][9], q_q[DEPTH-1]};
   assign dsat = sat_d(dd);
   // Shift once per stage-1 sample so the oldest slot is DEPTH samples back.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      end else if (adv_i) begin
         q_q[0] <= err_q;
         for (int i = 1; i < DEPTH; i++) q_q[i] <= q_q[i-1];
      end
`else
   assign dsat = '0;
`endif
   assign p_d = (term_t'(err_q) * PN) >>> 3;
   assign d_d = term_t'(dsat) * DC;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         err_q <= '0;
         p_q   <= '0;
         d_q   <= '0;
      end else begin
         if (vld_i) err_q <= err_d;
         if (adv_i) begin
            p_q <= p_d;
            d_q <= d_d;
         end
      end
   assign p_o = p_q;
   assign d_o = d_q;
endmodule

// File: rtl/attitude_pd_mixer.sv
// attitude_pd_mixer: 3-stage PD attitude controller mixing thrust into four motor speeds.
// Define PD_DTERM_EN to build the derivative queues and D terms.
module attitude_pd_mixer
   import attitude_pd_pkg::*;
#(
   parameter int D_QUEUE_DEPTH = 12,
   parameter int P_NUM         = 5,
   parameter int D_COEFF       = 2
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               vld,
   input  logic signed [15:0] ptch,
   input  logic signed [15:0] roll,
   input  logic signed [15:0] yaw,
   input  logic signed [15:0] d_ptch,
   input  logic signed [15:0] d_roll,
   input  logic signed [15:0] d_yaw,
   input  logic [8:0]         thrst,
   input  logic               inertial_cal,
   output logic [10:0]        frnt_spd,
   output logic [10:0]        bck_spd,
   output logic [10:0]        lft_spd,
   output logic [10:0]        rght_spd,
   output logic               out_vld
);
   logic       v1_q, v2_q, cal1_q, cal2_q, out_vld_q;
   logic [8:0] thr1_q, thr2_q;
   term_t      pp, dp, pr, dr, py, dy, base, pt, rt, yt;
   spd_t       frnt_d, bck_d, lft_d, rght_d, frnt_q, bck_q, lft_q, rght_q;
   pd_axis #(.DEPTH(D_QUEUE_DEPTH), .P_NUM(P_NUM), .D_COEFF(D_COEFF)) u_ptch (
      .clk(clk), .rst(rst), .vld_i(vld), .adv_i(v1_q),
      .meas_i(ptch), .des_i(d_ptch), .p_o(pp), .d_o(dp)
   );
   pd_axis #(.DEPTH(D_QUEUE_DEPTH), .P_NUM(P_NUM), .D_COEFF(D_COEFF)) u_roll (
      .clk(clk), .rst(rst), .vld_i(vld), .adv_i(v1_q),
      .meas_i(roll), .des_i(d_roll), .p_o(pr), .d_o(dr)
   );
   pd_axis #(.DEPTH(D_QUEUE_DEPTH), .P_NUM(P_NUM), .D_COEFF(D_COEFF)) u_yaw (
      .clk(clk), .rst(rst), .vld_i(vld), .adv_i(v1_q),
      .meas_i(yaw), .des_i(d_yaw), .p_o(py), .d_o(dy)
   );
   assign base = term_t'(MIN_RUN_SPEED) + term_t'(thr2_q);
   assign pt   = pp + dp;
   assign rt   = pr + dr;
   assign yt   = py + dy;
   // Calibration outranks zero thrust; both still let the queues advance.
   always_comb begin
      frnt_d = cal2_q ? CAL_SPEED : (thr2_q == '0) ? '0 : clamp_spd(base + pt - yt);
      bck_d  = cal2_q ? CAL_SPEED : (thr2_q == '0) ? '0 : clamp_spd(base - pt - yt);
      lft_d  = cal2_q ? CAL_SPEED : (thr2_q == '0) ? '0 : clamp_spd(base - rt + yt);
      rght_d = cal2_q ? CAL_SPEED : (thr2_q == '0) ? '0 : clamp_spd(base + rt + yt);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         cal1_q    <= 1'b0;
         cal2_q    <= 1'b0;
         thr1_q    <= '0;
         thr2_q    <= '0;
         out_vld_q <= 1'b0;
         frnt_q    <= '0;
         bck_q     <= '0;
         lft_q     <= '0;
         rght_q    <= '0;
      end else begin
         v1_q      <= vld;
         v2_q      <= v1_q;
         out_vld_q <= v2_q;
         if (vld) begin
            cal1_q <= inertial_cal;
            thr1_q <= thrst;
         end
         if (v1_q) begin
            cal2_q <= cal1_q;
            thr2_q <= thr1_q;
         end
         if (v2_q) begin
            frnt_q <= frnt_d;
            bck_q  <= bck_d;
            lft_q  <= lft_d;
            rght_q <= rght_d;
         end
      end
   assign frnt_spd = frnt_q;
   assign bck_spd  = bck_q;
   assign lft_spd  = lft_q;
   assign rght_spd = rght_q;
   assign out_vld  = out_vld_q;
endmodule

// File: tb/tb_attitude_pd_mixer.sv
// tb_attitude_pd_mixer: directed self-checking bench; expected speeds follow PD_DTERM_EN.
module tb_attitude_pd_mixer;
`ifdef PD_DTERM_EN
   localparam bit DT = 1'b1;
`else
   localparam bit DT = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, vld = 1'b0, inertial_cal = 1'b0;
   logic signed [15:0] ptch = '0, roll = '0, yaw = '0, d_ptch = '0, d_roll = '0, d_yaw = '0;
   logic [8:0]  thrst = '0;
   logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
   logic        out_vld;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   attitude_pd_mixer dut (
      .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .roll(roll), .yaw(yaw),
      .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst),
      .inertial_cal(inertial_cal), .frnt_spd(frnt_spd), .bck_spd(bck_spd),
      .lft_spd(lft_spd), .rght_spd(rght_spd), .out_vld(out_vld)
   );

   task automatic apply(input logic signed [15:0] p, dp, r, y, input logic [8:0] t, input logic c);
      ptch = p; d_ptch = dp; roll = r; d_roll = '0; yaw = y; d_yaw = '0; thrst = t; inertial_cal = c;
   endtask

   // Drives one vld and returns at the negedge where its result should be visible.
   task automatic send(input logic signed [15:0] p, dp, r, y, input logic [8:0] t, input logic c);
      apply(p, dp, r, y, t, c);
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset;
      vld = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_vld, frnt_spd, bck_spd, lft_spd, rght_spd} !== '0) begin
         failures++;
         $display("FAIL reset_hold: got vld=%0b f=%0d b=%0d l=%0d r=%0d want all 0", out_vld, frnt_spd, bck_spd, lft_spd, rght_spd);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_vld, frnt_spd, bck_spd, lft_spd, rght_spd} !== '0) begin
         failures++;
         $display("FAIL reset_release: got vld=%0b f=%0d b=%0d l=%0d r=%0d want all 0", out_vld, frnt_spd, bck_spd, lft_spd, rght_spd);
      end
   endtask

   task automatic test_single_step;
      logic [10:0] ef, eb;
      ef = DT ? 11'd800 : 11'd674;
      eb = DT ? 11'd424 : 11'd550;
      apply(16'sd100, '0, '0, '0, 9'd100, 1'b0);
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         checks++;
         if (out_vld !== (i == 3)) begin
            failures++;
            $display("FAIL step_latency: cycle N+%0d out_vld=%0b want %0b", i, out_vld, (i == 3));
         end
         if (i < 3) @(negedge clk);
      end
      checks++;
      if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {ef, eb, 11'd612, 11'd612}) begin
         failures++;
         $display("FAIL step_speeds: got f=%0d b=%0d l=%0d r=%0d want f=%0d b=%0d l=612 r=612", frnt_spd, bck_spd, lft_spd, rght_spd, ef, eb);
      end
      @(negedge clk);
      checks++;
      if ({out_vld, frnt_spd, bck_spd} !== {1'b0, ef, eb}) begin
         failures++;
         $display("FAIL step_hold: got vld=%0b f=%0d b=%0d want vld=0 f=%0d b=%0d", out_vld, frnt_spd, bck_spd, ef, eb);
      end
   endtask

   // Two idle cycles separate every vld; only the 13th sample sees a zero derivative.
   task automatic test_deriv_gaps;
      logic [10:0] ef, eb;
      do_reset;
      for (int k = 1; k <= 13; k++) begin
         send(16'sd100, '0, '0, '0, 9'd100, 1'b0);
         ef = (DT && k < 13) ? 11'd800 : 11'd674;
         eb = (DT && k < 13) ? 11'd424 : 11'd550;
         checks++;
         if ({out_vld, frnt_spd, bck_spd} !== {1'b1, ef, eb}) begin
            failures++;
            $display("FAIL deriv_pulse%0d: got vld=%0b f=%0d b=%0d want vld=1 f=%0d b=%0d", k, out_vld, frnt_spd, bck_spd, ef, eb);
         end
      end
   endtask

   task automatic test_saturation;
      logic [10:0] ef, eb, el;
      do_reset;
      send(16'sh7FFF, 16'sh8000, '0, '0, 9'd511, 1'b0);
      ef = DT ? 11'd1468 : 11'd1342;
      eb = DT ? 11'd578 : 11'd704;
      checks++;
      if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {ef, eb, 11'd1023, 11'd1023}) begin
         failures++;
         $display("FAIL sat_pos: got f=%0d b=%0d l=%0d r=%0d want f=%0d b=%0d l=1023 r=1023", frnt_spd, bck_spd, lft_spd, rght_spd, ef, eb);
      end
      do_reset;
      send(16'sh8000, 16'sh7FFF, '0, '0, 9'd511, 1'b0);
      ef = DT ? 11'd575 : 11'd703;
      eb = DT ? 11'd1471 : 11'd1343;
      checks++;
      if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {ef, eb, 11'd1023, 11'd1023}) begin
         failures++;
         $display("FAIL sat_neg: got f=%0d b=%0d l=%0d r=%0d want f=%0d b=%0d l=1023 r=1023", frnt_spd, bck_spd, lft_spd, rght_spd, ef, eb);
      end
      do_reset;
      send(16'sh7FFF, 16'sh8000, '0, 16'sh7FFF, 9'd1, 1'b0);
      el = DT ? 11'd958 : 11'd832;
      checks++;
      if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {11'd513, 11'd0, el, el}) begin
         failures++;
         $display("FAIL clamp_low: got f=%0d b=%0d l=%0d r=%0d want f=513 b=0 l=%0d r=%0d", frnt_spd, bck_spd, lft_spd, rght_spd, el, el);
      end
   endtask

   task automatic test_axes;
      logic [10:0] el, er;
      do_reset;
      send('0, '0, -16'sd80, '0, 9'd200, 1'b0);
      el = DT ? 11'd890 : 11'd762;
      er = DT ? 11'd534 : 11'd662;
      checks++;
      if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {11'd712, 11'd712, el, er}) begin
         failures++;
         $display("FAIL roll_axis: got f=%0d b=%0d l=%0d r=%0d want f=712 b=712 l=%0d r=%0d", frnt_spd, bck_spd, lft_spd, rght_spd, el, er);
      end
      send('0, '0, '0, 16'sd80, 9'd200, 1'b0);
      el = DT ? 11'd536 : 11'd662;
      er = DT ? 11'd888 : 11'd762;
      checks++;
      if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {el, el, er, er}) begin
         failures++;
         $display("FAIL yaw_axis: got f=%0d b=%0d l=%0d r=%0d want f=%0d b=%0d l=%0d r=%0d", frnt_spd, bck_spd, lft_spd, rght_spd, el, el, er, er);
      end
   endtask

   task automatic test_overrides;
      send(16'sd100, '0, 16'sd37, -16'sd9, 9'd100, 1'b1);
      checks++;
      if ({out_vld, frnt_spd, bck_spd, lft_spd, rght_spd} !== {1'b1, {4{11'h290}}}) begin
         failures++;
         $display("FAIL cal_override: got vld=%0b f=%0d b=%0d l=%0d r=%0d want vld=1 all 656", out_vld, frnt_spd, bck_spd, lft_spd, rght_spd);
      end
      send(16'sd100, '0, 16'sd37, -16'sd9, 9'd0, 1'b0);
      checks++;
      if ({out_vld, frnt_spd, bck_spd, lft_spd, rght_spd} !== {1'b1, 44'd0}) begin
         failures++;
         $display("FAIL zero_thrust: got vld=%0b f=%0d b=%0d l=%0d r=%0d want vld=1 all 0", out_vld, frnt_spd, bck_spd, lft_spd, rght_spd);
      end
   endtask

   task automatic test_back_to_back;
      logic [10:0] ef [4];
      logic [10:0] eb [4];
      ef = DT ? '{11'd800, 11'd863, 11'd925, 11'd988} : '{11'd674, 11'd737, 11'd799, 11'd862};
      eb = DT ? '{11'd424, 11'd361, 11'd299, 11'd236} : '{11'd550, 11'd487, 11'd425, 11'd362};
      do_reset;
      for (int i = 0; i < 8; i++) begin
         if (i >= 3 && i < 7) begin
            checks++;
            if ({out_vld, frnt_spd, bck_spd} !== {1'b1, ef[i-3], eb[i-3]}) begin
               failures++;
               $display("FAIL b2b_out%0d: got vld=%0b f=%0d b=%0d want vld=1 f=%0d b=%0d", i - 3, out_vld, frnt_spd, bck_spd, ef[i-3], eb[i-3]);
            end
         end
         if (i == 7) begin
            checks++;
            if (out_vld !== 1'b0) begin
               failures++;
               $display("FAIL b2b_end: got out_vld=%0b want 0", out_vld);
            end
         end
         if (i < 4) begin
            apply(16'(100 * (i + 1)), '0, '0, '0, 9'd100, 1'b0);
            vld = 1'b1;
         end else vld = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid;
      logic [10:0] ef;
      apply(16'sd100, '0, '0, '0, 9'd100, 1'b0);
      vld = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({out_vld, frnt_spd, bck_spd, lft_spd, rght_spd} !== '0) begin
            failures++;
            $display("FAIL rst_mid%0d: got vld=%0b f=%0d b=%0d l=%0d r=%0d want all 0", i, out_vld, frnt_spd, bck_spd, lft_spd, rght_spd);
         end
         @(negedge clk);
      end
      send(16'sd100, '0, '0, '0, 9'd100, 1'b0);
      ef = DT ? 11'd800 : 11'd674;
      checks++;
      if ({out_vld, frnt_spd} !== {1'b1, ef}) begin
         failures++;
         $display("FAIL rst_fresh: got vld=%0b f=%0d want vld=1 f=%0d", out_vld, frnt_spd, ef);
      end
   endtask

   initial begin
      test_reset;
      test_single_step;
      test_deriv_gaps;
      test_saturation;
      test_axes;
      test_overrides;
      test_back_to_back;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
